// File: rtl/raster_to_block.sv
// raster_to_block: raster-order line beats in, 8x8 block rows out.
//
// Two 8-line band buffers ping-pong. The write side fills one band in raster
// order (row-major over 8 lines x BLK_W column beats). The read side drains the
// other band block by block (column beat major, 8 rows per block).
//
// Ports:
//   clk, rst               clock, async active-high reset
//   in_valid/in_ready      input beat handshake
//   in_data[7:0]           8 pixels of a line, element 0 leftmost
//   in_sof                 first beat of a frame (restarts the band)
//   out_valid/out_ready    output row handshake
//   out_data[7:0]          one block row, element 0 leftmost
//   out_sob/out_eob        first/last row of a block
//   out_sof                first row of the first block of a sof band
module raster_to_block #(
  parameter int W_IO  = 16,
  parameter int IMG_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0][W_IO-1:0] in_data,
  input  logic                 in_sof,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0][W_IO-1:0] out_data,
  output logic                 out_sob,
  output logic                 out_eob,
  output logic                 out_sof
);
  localparam int BLK_W = IMG_W / 8;
  localparam int CW    = (BLK_W > 1) ? $clog2(BLK_W) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(BLK_W - 1);

  typedef logic [7:0][W_IO-1:0] word_t;

  word_t          band [2][8][BLK_W];
  logic [1:0]     band_full, band_sof;
  logic           wr_sel, rd_sel;
  logic [2:0]     wr_row, rd_row;
  logic [CW-1:0]  wr_col, rd_blk;

  logic           wr_en, wr_last, rd_en, rd_last;
  logic [2:0]     wa_row;
  logic [CW-1:0]  wa_col;
  logic [1:0]     full_set, full_clr;

  // in_sof forces the beat to the band origin; everything after it advances
  // from there, so a partially filled band is simply overwritten.
  assign wa_row  = in_sof ? 3'd0 : wr_row;
  assign wa_col  = in_sof ? '0   : wr_col;

  assign in_ready = ~band_full[wr_sel];
  assign wr_en    = in_valid & in_ready;
  assign wr_last  = (wa_row == 3'd7) && (wa_col == COL_LAST);

  assign out_valid = band_full[rd_sel];
  assign rd_en     = out_valid & out_ready;
  assign rd_last   = (rd_row == 3'd7) && (rd_blk == COL_LAST);

  assign out_data = band[rd_sel][rd_row][rd_blk];
  assign out_sob  = out_valid & (rd_row == 3'd0);
  assign out_eob  = out_valid & (rd_row == 3'd7);
  assign out_sof  = out_valid & band_sof[rd_sel] & (rd_blk == '0) & (rd_row == 3'd0);

  // Completion and release always hit different bands, so they can be
  // applied independently in the same cycle.
  assign full_set = (wr_en && wr_last) ? (2'b01 << wr_sel) : 2'b00;
  assign full_clr = (rd_en && rd_last) ? (2'b01 << rd_sel) : 2'b00;

  // Band storage; cleared on reset so out_data reads 0 afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < 8; r++)
          for (int c = 0; c < BLK_W; c++)
            band[b][r][c] <= '0;
    end else if (wr_en) begin
      band[wr_sel][wa_row][wa_col] <= in_data;
    end
  end

  // Write-side pointers and per-band sof flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_sel   <= 1'b0;
      wr_row   <= 3'd0;
      wr_col   <= '0;
      band_sof <= 2'b00;
    end else if (wr_en) begin
      if (in_sof)
        band_sof[wr_sel] <= 1'b1;
      else if (wa_row == 3'd0 && wa_col == '0)
        band_sof[wr_sel] <= 1'b0;
      if (wr_last) begin
        wr_sel <= ~wr_sel;
        wr_row <= 3'd0;
        wr_col <= '0;
      end else if (wa_col == COL_LAST) begin
        wr_col <= '0;
        wr_row <= wa_row + 3'd1;
      end else begin
        wr_col <= wa_col + CW'(1);
        wr_row <= wa_row;
      end
    end
  end

  // Read-side pointers: rows fastest, then blocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_sel <= 1'b0;
      rd_row <= 3'd0;
      rd_blk <= '0;
    end else if (rd_en) begin
      if (rd_last) begin
        rd_sel <= ~rd_sel;
        rd_row <= 3'd0;
        rd_blk <= '0;
      end else if (rd_row == 3'd7) begin
        rd_row <= 3'd0;
        rd_blk <= rd_blk + CW'(1);
      end else begin
        rd_row <= rd_row + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) band_full <= 2'b00;
    else     band_full <= (band_full | full_set) & ~full_clr;
  end

endmodule

// File: tb/tb_raster_to_block.sv
// Self-checking bench for raster_to_block (IMG_W=16, two beats per line).
// A line/band model builds expected block rows into a queue as beats are
// accepted; rows are popped and compared as the DUT transfers them.
module tb_raster_to_block;
  localparam int W_IO  = 16;
  localparam int IMG_W = 16;
  localparam int BLK_W = IMG_W / 8;

  typedef logic [7:0][W_IO-1:0] pix_t;
  typedef struct {
    pix_t d;
    logic sob, eob, sof;
  } exp_t;
  typedef struct {
    logic v, s;
    int   beat;
    logic e_rdy, e_ov, e_sob, e_eob, e_sof;
  } vec_t;

  logic clk, rst;
  logic in_valid, in_ready, in_sof;
  logic out_valid, out_ready, out_sob, out_eob, out_sof;
  pix_t in_data, out_data;

  raster_to_block #(.W_IO(W_IO), .IMG_W(IMG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sof(in_sof),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sob(out_sob), .out_eob(out_eob), .out_sof(out_sof)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   fails  = 0;
  exp_t q[$];
  pix_t mb [8][BLK_W];
  int   mr = 0, mc = 0;
  logic msof = 1'b0;

  task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic pix_t mkdata(int b);
    pix_t r;
    for (int k = 0; k < 8; k++) r[k] = 16'(b * 8 + k);
    return r;
  endfunction

  // Band model: raster beats in, block-order rows pushed on band completion.
  task automatic mwrite(pix_t d, logic s);
    exp_t e;
    if (s) begin mr = 0; mc = 0; end
    if (mr == 0 && mc == 0) msof = s;
    mb[mr][mc] = d;
    mc++;
    if (mc == BLK_W) begin mc = 0; mr++; end
    if (mr == 8) begin
      mr = 0;
      for (int blk = 0; blk < BLK_W; blk++)
        for (int r = 0; r < 8; r++) begin
          e.d   = mb[r][blk];
          e.sob = (r == 0);
          e.eob = (r == 7);
          e.sof = msof && blk == 0 && r == 0;
          q.push_back(e);
        end
    end
  endtask

  // Sampled once per cycle at the falling edge.
  task automatic smp();
    exp_t e;
    @(negedge clk);
    if (rst) begin
      q.delete(); mr = 0; mc = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_row", 1'b1, 1'b0);
        else begin
          e = q.pop_front();
          chk("row", {out_data, out_sob, out_eob, out_sof}, {e.d, e.sob, e.eob, e.sof});
        end
      end
      if (in_valid && in_ready) mwrite(in_data, in_sof);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b0;
    smp(); tick(); smp(); tick();
    rst = 1'b0;
  endtask

  // Feed n beats; in_valid is held while a presented beat waits.
  task automatic feed(int n, int base, bit sof0, int pv, int pr, bit flow);
    int bi = 0, cyc = 0;
    bit acc;
    in_valid = 1'b0;
    while (bi < n && cyc < 4000) begin
      if (!in_valid) in_valid = ($urandom_range(99) < pv);
      in_data   = mkdata(base + bi);
      in_sof    = sof0 && bi == 0;
      out_ready = ($urandom_range(99) < pr);
      smp();
      if (flow) begin
        chk("in_ready_cont", in_ready, 1'b1);
        if (bi >= 8 * BLK_W) chk("gapless", out_valid, 1'b1);
      end
      acc = in_valid && in_ready;
      tick();
      cyc++;
      if (acc) begin bi++; in_valid = 1'b0; end
    end
    in_valid = 1'b0; in_sof = 1'b0;
    if (bi < n) chk("feed_timeout", 1'b1, 1'b0);
  endtask

  task automatic drain();
    int c = 0;
    in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
    while ((q.size() > 0 || out_valid) && c < 300) begin
      smp(); tick(); c++;
    end
    chk("drain_done", {q.size() == 0, out_valid}, 2'b10);
  endtask

  vec_t tbl [33];

  initial begin
    int   bi;
    bit   acc;
    exp_t e;

    for (int i = 0; i < 33; i++) begin
      tbl[i].v = (i < 16); tbl[i].s = (i == 0); tbl[i].beat = (i < 16) ? i : 0;
      tbl[i].e_rdy = 1'b1;
      tbl[i].e_ov  = (i >= 16 && i < 32);
      tbl[i].e_sob = (i >= 16 && i < 32) && ((i - 16) % 8 == 0);
      tbl[i].e_eob = (i >= 16 && i < 32) && ((i - 16) % 8 == 7);
      tbl[i].e_sof = (i == 16);
    end

    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b0; in_data = '0;
    #1;
    chk("reset_state", {in_ready, out_valid, out_sob, out_eob, out_sof}, 5'b10000);
    chk("reset_data", out_data, '0);
    do_reset();

    // Single band: pixel = line*16 + col, latency and framing per cycle.
    for (int i = 0; i < 33; i++) begin
      in_valid = tbl[i].v; in_sof = tbl[i].s; in_data = mkdata(tbl[i].beat); out_ready = 1'b1;
      smp();
      chk($sformatf("vec%0d", i), {in_ready, out_valid, out_sob, out_eob, out_sof},
          {tbl[i].e_rdy, tbl[i].e_ov, tbl[i].e_sob, tbl[i].e_eob, tbl[i].e_sof});
      tick();
    end
    chk("single_empty", q.size(), 0);

    // Continuous 4-band frame, full throughput.
    feed(4 * 8 * BLK_W, 100, 1'b1, 100, 100, 1'b1);
    drain();

    // Backpressure: out_ready low 40 cycles after band 0 fills.
    do_reset();
    bi = 0; in_valid = 1'b1; out_ready = 1'b0;
    for (int c = 0; c < 100 && bi < 16; c++) begin
      in_data = mkdata(5000 + bi); in_sof = (bi == 0);
      smp(); acc = in_valid && in_ready; tick();
      if (acc) bi++;
    end
    for (int k = 0; k < 40; k++) begin
      in_data = mkdata(5000 + bi); in_sof = 1'b0;
      smp();
      chk($sformatf("bp_rdy%0d", k), in_ready, (k < 16));
      if (q.size() == 0) chk("bp_queue", 1'b1, 1'b0);
      else begin
        e = q[0];
        chk("bp_hold", {out_valid, out_data, out_sob, out_eob, out_sof}, {1'b1, e.d, 1'b1, 1'b0, 1'b1});
      end
      acc = in_valid && in_ready; tick();
      if (acc) bi++;
    end
    out_ready = 1'b1;
    for (int j = 0; j <= 16; j++) begin
      in_data = mkdata(5000 + bi);
      smp();
      chk($sformatf("bp_release%0d", j), in_ready, (j == 16));
      acc = in_valid && in_ready; tick();
      if (acc) bi++;
    end
    chk("bp_beats", bi, 33);
    feed(15, 5033, 1'b0, 100, 100, 1'b0);
    drain();

    // Mid-band sof after 5 beats abandons the partial band.
    do_reset();
    feed(5, 1000, 1'b0, 100, 100, 1'b0);
    feed(16, 2000, 1'b1, 100, 100, 1'b0);
    smp();
    chk("midsof_first", {out_valid, out_sof, out_sob, out_data}, {3'b111, mkdata(2000)});
    tick();
    drain();

    // Random handshakes over 20 bands.
    do_reset();
    feed(20 * 8 * BLK_W, 6000, 1'b1, 50, 50, 1'b0);
    drain();

    // Async reset mid-drain.
    do_reset();
    feed(16, 3000, 1'b1, 100, 0, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin smp(); tick(); end
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_flags", {in_ready, out_valid, out_sob, out_eob, out_sof}, 5'b10000);
    chk("rst_mid_data", out_data, '0);
    for (int i = 0; i < 3; i++) begin smp(); tick(); end
    rst = 1'b0;
    feed(16, 4000, 1'b0, 100, 100, 1'b0);
    smp();
    chk("post_rst_first", {out_valid, out_sob, out_sof, out_data}, {3'b110, mkdata(4000)});
    tick();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
